// File: rtl/booth_divider_seq.sv
// Sequential signed divider: a non-restoring core working on operand magnitudes
// produces one quotient bit per clock, then a single fixup edge restores the signs.
module booth_divider_seq #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] prem_q, prem_d;
    // Dividend magnitude shifts out at the top while quotient bits shift in at the bottom
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          div_by_zero_q, div_by_zero_d;

    logic [PW-1:0] prem_sh;
    logic [PW-1:0] prem_alu;
    logic [PW-1:0] prem_fix;
    logic [N-1:0]  rem_mag;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            prem_q        <= '0;
            acc_q         <= '0;
            dvs_q         <= '0;
            dvd_q         <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prem_q        <= prem_d;
            acc_q         <= acc_d;
            dvs_q         <= dvs_d;
            dvd_q         <= dvd_d;
            qneg_q        <= qneg_d;
            rneg_q        <= rneg_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    // Next-state, iteration step and sign fixup
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prem_d        = prem_q;
        acc_d         = acc_q;
        dvs_d         = dvs_q;
        dvd_d         = dvd_q;
        qneg_d        = qneg_q;
        rneg_d        = rneg_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        // Sign of the current partial remainder picks subtract or add-back
        prem_sh  = {prem_q[N-1:0], acc_q[N-1]};
        prem_alu = prem_q[N] ? (prem_sh + {1'b0, dvs_q}) : (prem_sh - {1'b0, dvs_q});
        prem_fix = prem_q[N] ? (prem_q + {1'b0, dvs_q}) : prem_q;
        rem_mag  = prem_fix[N-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d         = dividend;
                    qneg_d        = dividend[N-1] ^ divisor[N-1];
                    rneg_d        = dividend[N-1];
                    acc_d         = dividend[N-1] ? (-dividend) : dividend;
                    dvs_d         = divisor[N-1] ? (-divisor) : divisor;
                    prem_d        = '0;
                    cnt_d         = CW'(N);
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    state_d       = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                prem_d = prem_alu;
                acc_d  = {acc_q[N-2:0], ~prem_alu[N]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                // A zero divisor magnitude only arises from a zero divisor
                if (dvs_q == '0) begin
                    quotient_d    = '1;
                    remainder_d   = dvd_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d  = qneg_q ? (-acc_q) : acc_q;
                    remainder_d = rneg_q ? (-rem_mag) : rem_mag;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed bench for booth_divider_seq: an 8-bit instance for hand-computed vectors
// and a 4-bit instance swept over every operand pair against a truncating model.
module tb_booth_divider_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, dz8;
    logic [7:0] dvd8, dvs8, q8, r8;
    logic       start4, busy4, done4, dz4;
    logic [3:0] dvd4, dvs4, q4, r4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_divider_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    booth_divider_seq #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dz4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Call just before a rising edge; returns #1 after the accepting edge
    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        dvd8   = a;
        dvs8   = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        dvd8   = 8'hAA;
        dvs8   = 8'h55;
    endtask

    task automatic wait8(output int lat, output int bcnt);
        lat  = 0;
        bcnt = int'(busy8);
        while (!done8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            bcnt += int'(busy8);
        end
        if (!done8) check("timeout8", 32'd0, 32'd1);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz,
                       input int elat);
        int lat, bc;
        @(negedge clk);
        launch8(a, b);
        wait8(lat, bc);
        check({tag, " quotient"}, 32'(q8), 32'(eq));
        check({tag, " remainder"}, 32'(r8), 32'(er));
        check({tag, " div_by_zero"}, 32'(dz8), 32'(edz));
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " busy cycles"}, 32'(bc), 32'(elat));
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int lat, sa, sb, eq, er;
        logic [12:0] got, exp;
        @(negedge clk);
        dvd4   = a;
        dvs4   = b;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            exp = {4'd1, 1'b1, 4'hF, a};
        end else begin
            eq  = sa / sb;
            er  = sa % sb;
            exp = {4'd5, 1'b0, 4'(eq), 4'(er)};
        end
        got = {4'(lat), dz4, q4, r4};
        check($sformatf("sweep %0d/%0d {lat,dz,q,r}", sa, sb), 32'(got), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dones;
        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        dvd8   = '0;
        dvs8   = '0;
        dvd4   = '0;
        dvs4   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {busy8, done8, dz8, q8, r8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op8("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9);
        op8("-100/7", 8'(-100), 8'd7, 8'hF2, 8'hFE, 1'b0, 9);
        op8("100/-7", 8'd100, 8'(-7), 8'hF2, 8'h02, 1'b0, 9);
        op8("-100/-7", 8'(-100), 8'(-7), 8'h0E, 8'hFE, 1'b0, 9);
        op8("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
        op8("-128/1", 8'h80, 8'd1, 8'h80, 8'h00, 1'b0, 9);
        op8("7/100", 8'd7, 8'd100, 8'h00, 8'h07, 1'b0, 9);
        op8("5/0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1);
        op8("9/3", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 9);

        // Abort: ignored restart at k+3, reset at k+6
        @(negedge clk);
        launch8(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        launch8(8'd50, 8'd5);
        check("abort busy after ignored start", 32'(busy8), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort reset outputs", {busy8, done8, dz8, q8, r8}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            dones += int'(done8);
        end
        check("abort no done", 32'(dones), 32'd0);
        check("abort outputs held at zero", {busy8, dz8, q8, r8}, 32'd0);
        op8("50/5", 8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 9);

        // Back-to-back: second start issued in the done cycle
        @(negedge clk);
        launch8(8'd100, 8'd7);
        wait8(lat, bc);
        check("b2b first quotient", 32'(q8), 32'h0E);
        launch8(8'd127, 8'd2);
        check("b2b accepted busy", 32'(busy8), 32'd1);
        check("b2b result held", {q8, r8}, 32'h0E02);
        wait8(lat, bc);
        check("b2b second latency", 32'(lat), 32'd9);
        check("b2b second result", {dz8, q8, r8}, 32'h03F01);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op4(4'(i), 4'(j));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential signed two's-complement divider. It is the inverse-operation companion to the team's iterative Booth multiplier, and produces quotient and remainder from an N-bit dividend and divisor.
- Uses a non-restoring shift/add-subtract core on operand magnitudes, one quotient bit per clock, followed by a sign-fixup stage.
- Sits in the arithmetic-unit datapath with a start/busy/done handshake, so a controller can issue back-to-back operations.

Parameters:
- N, 4, operand width in bits (N >= 2); quotient and remainder are also N bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while idle.
- dividend  input  N  signed dividend; captured on the accepting edge.
- divisor  input  N  signed divisor; captured on the accepting edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  N  signed quotient, truncated toward zero.
- remainder  output  N  signed remainder; sign follows the dividend, or it is zero.
- div_by_zero  output  1  set with done when the divisor was zero.

Behaviour:
- Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter cleared.
- Reset mid-operation: the operation is abandoned, all outputs go to their reset values, and no done is issued.
- States: IDLE, CALC, FIX.
- IDLE, start=1 sampled at edge k:
  - Capture the operands.
  - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Load magnitudes as unsigned N-bit values; |-2^(N-1)| = 2^(N-1) must be representable.
  - Clear the partial remainder: N+1 bits, signed.
  - Counter = N.
  - busy=1.
  - Next state is CALC, or FIX directly if divisor==0.
- CALC, one edge per quotient bit:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If the partial remainder was non-negative, subtract the divisor magnitude; otherwise add it.
  - The new quotient LSB is the inverse of the result's sign bit.
  - Counter decrements.
  - After exactly N CALC edges (edges k+1..k+N), the next state is FIX.
- FIX, one edge (k+N+1):
  - If the partial remainder is negative, add the divisor magnitude back.
  - Negate the quotient and/or remainder magnitudes per the recorded signs.
  - Register the outputs. done=1 for one cycle, busy=0, state goes to IDLE.
- Latency: done is high in the cycle after edge k+N+1 (N+1 edges after the accepting edge). For divide-by-zero it is 1 edge after (k+1).
- Divide-by-zero result: quotient = all ones (-1), remainder = original dividend, div_by_zero=1.
- div_by_zero is cleared on the next accepted start.
- Overflow case -2^(N-1) / -1: quotient wraps to -2^(N-1) (0b10..0), remainder=0. No flag; wrap is the defined result.
- start while busy (CALC or FIX): ignored, with no effect on the operands or the in-flight result.
- start in the same cycle as done: accepted, since the block is IDLE. Results stay on the outputs until the next FIX edge overwrites them.
- quotient, remainder and div_by_zero hold their values between operations; only done pulses.
- Operand inputs may change freely after the accepting edge.
- No combinational path from any input to any output.

Test Plan (N=8 unless noted):
- 100 / 7 -> quotient=14 (0x0E), remainder=2; done exactly 9 edges after start, busy high for those 9 edges.
- -100 / 7 -> 0xF2 (-14), 0xFE (-2). 100 / -7 -> 0xF2, 0x02. -100 / -7 -> 0x0E, 0xFE.
- -128 / -1 -> quotient=0x80, remainder=0x00, div_by_zero=0. -128 / 1 -> 0x80, 0x00. 7 / 100 -> 0x00, 0x07.
- 5 / 0 -> div_by_zero=1, quotient=0xFF, remainder=0x05, done 1 edge after start. The next start of 9/3 gives 3, 0 and clears div_by_zero.
- Start 100/7, re-pulse start with 50/5 at edge k+3, then assert rst at edge k+6 -> no done, all outputs 0, busy=0. A fresh start of 50/5 gives 10, 0.
- Back-to-back: start 100/7, then start 127/2 in the done cycle -> second done 9 edges later with 63, 1. Exhaustive N=4 sweep of all 256 operand pairs against a truncating reference model.
